// File: rtl/mc_pkg.sv
// Shared types and constants for the mc_control multi-cycle instruction sequencer.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_IMM, ST_WB, ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU, CLS_MOV, CLS_LD, CLS_ST, CLS_LI, CLS_HALT, CLS_ILL
    } op_class_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_MOV  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_LI   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_MDR = 2'd1;
    localparam logic [1:0] WSEL_REG = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier: maps IR[7:4] to an instruction class and ALU op.
module mc_decode
    import mc_pkg::*;
(
    input  logic [3:0] op,
    output logic [2:0] op_class,
    output logic [2:0] alu_op
);

    always_comb begin
        op_class = CLS_ILL;
        alu_op   = ALU_ADD;
        case (op)
            OP_NOP:  op_class = CLS_NOP;
            OP_ADD:  begin op_class = CLS_ALU; alu_op = ALU_ADD; end
            OP_SUB:  begin op_class = CLS_ALU; alu_op = ALU_SUB; end
            OP_AND:  begin op_class = CLS_ALU; alu_op = ALU_AND; end
            OP_OR:   begin op_class = CLS_ALU; alu_op = ALU_OR;  end
            OP_MOV:  op_class = CLS_MOV;
            OP_LD:   op_class = CLS_LD;
            OP_ST:   op_class = CLS_ST;
            OP_LI:   op_class = CLS_LI;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the 8-bit, 4-register processor.
// Define MC_CONTROL_INSTRET_EN to build the retired-instruction counter.
module mc_control
    import mc_pkg::*;
#(
    parameter int N             = 8,
    parameter int RST_PC_EN_DLY = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic         mem_req,
    output logic         mem_we,
    output logic         addr_sel,
    output logic         pc_en,
    output logic         mdr_load,
    output logic [1:0]   rd0_num,
    output logic [1:0]   rd1_num,
    output logic [1:0]   wr_num,
    output logic         wr_en,
    output logic [1:0]   wr_sel,
    output logic [2:0]   alu_op,
    output logic         illegal,
    output logic         halted,
    output logic [15:0]  instret
);

    state_e       state_q, state_d;
    logic [N-1:0] ir_q, ir_d;
    logic [1:0]   dly_q, dly_d;
    logic [2:0]   op_class;
    logic [2:0]   dec_alu_op;
    logic [1:0]   rd, rs;

    assign rd = ir_q[3:2];
    assign rs = ir_q[1:0];

    mc_decode u_decode (
        .op       (ir_q[7:4]),
        .op_class (op_class),
        .alu_op   (dec_alu_op)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        dly_d   = dly_q;
        case (state_q)
            ST_IDLE: begin
                if (dly_q == 2'(RST_PC_EN_DLY)) state_d = ST_FETCH;
                else                            dly_d   = dly_q + 2'd1;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (op_class)
                    CLS_ALU, CLS_MOV: state_d = ST_EXEC;
                    CLS_LD, CLS_ST:   state_d = ST_MEM;
                    CLS_LI:           state_d = ST_IMM;
                    CLS_HALT:         state_d = ST_HALT;
                    default:          state_d = ST_FETCH;
                endcase
            end
            ST_EXEC: state_d = ST_FETCH;
            ST_MEM: begin
                if (mem_ack) state_d = (op_class == CLS_LD) ? ST_WB : ST_FETCH;
            end
            ST_IMM: begin
                if (mem_ack) state_d = ST_WB;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            dly_q   <= dly_d;
        end
    end

    // Outputs follow the registered state; reset forces every output low immediately.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        pc_en    = 1'b0;
        mdr_load = 1'b0;
        rd0_num  = 2'd0;
        rd1_num  = 2'd0;
        wr_num   = 2'd0;
        wr_en    = 1'b0;
        wr_sel   = WSEL_ALU;
        alu_op   = ALU_ADD;
        illegal  = 1'b0;
        halted   = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    pc_en   = mem_ack;
                end
                ST_DECODE: begin
                    rd0_num = rd;
                    rd1_num = rs;
                    illegal = (op_class == CLS_ILL);
                end
                ST_EXEC: begin
                    rd0_num = rd;
                    rd1_num = rs;
                    wr_num  = rd;
                    wr_en   = 1'b1;
                    if (op_class == CLS_MOV) wr_sel = WSEL_REG;
                    else                     alu_op = dec_alu_op;
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    rd0_num  = rd;
                    rd1_num  = rs;
                    mem_we   = (op_class == CLS_ST);
                    mdr_load = mem_ack && (op_class == CLS_LD);
                end
                ST_IMM: begin
                    mem_req  = 1'b1;
                    pc_en    = mem_ack;
                    mdr_load = mem_ack;
                end
                ST_WB: begin
                    wr_num = rd;
                    wr_sel = WSEL_MDR;
                    wr_en  = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_CONTROL_INSTRET_EN
    logic [15:0] instret_q, instret_d;
    logic        retire;

    // An instruction retires on the cycle it finishes its last state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            ST_EXEC, ST_WB: retire = 1'b1;
            ST_MEM:         retire = mem_ack && (op_class == CLS_ST);
            ST_DECODE:      retire = (op_class == CLS_NOP) || (op_class == CLS_ILL) ||
                                     (op_class == CLS_HALT);
            default:        retire = 1'b0;
        endcase
        instret_d = instret_q + {15'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (reset) instret_q <= '0;
        else       instret_q <= instret_d;
    end

    assign instret = reset ? 16'd0 : instret_q;
`else
    assign instret = 16'd0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed-vector bench for mc_control; inputs change and outputs are sampled around the negedge.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, addr_sel, pc_en, mdr_load, wr_en, illegal, halted;
    logic [1:0]  rd0_num, rd1_num, wr_num, wr_sel;
    logic [2:0]  alu_op;
    logic [15:0] instret;

    int vectors = 0;
    int miscompares = 0;

    mc_control dut (
        .clk       (clk),
        .reset     (reset),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .pc_en     (pc_en),
        .mdr_load  (mdr_load),
        .rd0_num   (rd0_num),
        .rd1_num   (rd1_num),
        .wr_num    (wr_num),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .alu_op    (alu_op),
        .illegal   (illegal),
        .halted    (halted),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic wait_req();
        for (int i = 0; i < 50; i++) begin
            if (mem_req === 1'b1) return;
            @(negedge clk); #1;
        end
        vectors++; miscompares++;
        $display("[TB] FAIL wait_req: mem_req=%0b after 50 cycles, expected 1", mem_req);
    endtask

    task automatic feed(input logic [7:0] b);
        wait_req();
        mem_ack = 1'b1; mem_rdata = b;
        @(negedge clk); mem_ack = 1'b0; #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({mem_req, mem_we, addr_sel, pc_en, mdr_load, rd0_num, rd1_num, wr_num, wr_en,
             wr_sel, alu_op, illegal, halted, instret} !== 35'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got req=%0b pc_en=%0b wr_en=%0b instret=%0d, expected all 0",
                     mem_req, pc_en, wr_en, instret);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_add();
        reset = 1'b0;
        @(negedge clk); #1;
        wait_req();
        vectors++;
        if ({addr_sel, mem_we} !== 2'b00) begin
            miscompares++; $display("[TB] FAIL fetch_qual: got %b expected 00", {addr_sel, mem_we});
        end
        mem_ack = 1'b1; mem_rdata = 8'h16; #1;
        vectors++;
        if (pc_en !== 1'b1) begin miscompares++; $display("[TB] FAIL add_pc_en: got %b expected 1", pc_en); end
        @(negedge clk); mem_ack = 1'b0; #1;
        vectors++;
        if ({rd0_num, rd1_num, wr_en} !== {2'd1, 2'd2, 1'b0}) begin
            miscompares++; $display("[TB] FAIL add_decode: got %b expected 01100", {rd0_num, rd1_num, wr_en});
        end
        @(negedge clk); #1;
        vectors++;
        if ({wr_en, wr_num, wr_sel, alu_op, mem_req} !== {1'b1, 2'd1, 2'd0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL add_exec: got %b expected 101000000", {wr_en, wr_num, wr_sel, alu_op, mem_req});
        end
        @(negedge clk); #1;
        vectors++;
        if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL add_refetch: got %b expected 1", mem_req); end
    endtask

    task automatic test_ld_wait();
        wait_req();
        mem_ack = 1'b1; mem_rdata = 8'h6B;
        @(negedge clk); mem_ack = 1'b0; #1;
        vectors++;
        if ({rd0_num, rd1_num} !== {2'd2, 2'd3}) begin
            miscompares++; $display("[TB] FAIL ld_decode: got %b expected 1011", {rd0_num, rd1_num});
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3); mem_rdata = 8'h33; #1;
            vectors++;
            if ({mem_req, addr_sel, mem_we, rd1_num, wr_en} !== {1'b1, 1'b1, 1'b0, 2'd3, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL ld_mem_hold[%0d]: got %b expected 110110", i, {mem_req, addr_sel, mem_we, rd1_num, wr_en});
            end
            vectors++;
            if (mdr_load !== 1'(i == 3)) begin
                miscompares++; $display("[TB] FAIL ld_mdr_load[%0d]: got %b expected %b", i, mdr_load, (i == 3));
            end
            @(negedge clk);
        end
        mem_ack = 1'b0; #1;
        vectors++;
        if ({wr_num, wr_sel, wr_en, mem_req} !== {2'd2, 2'd1, 1'b1, 1'b0}) begin
            miscompares++; $display("[TB] FAIL ld_wb: got %b expected 100110", {wr_num, wr_sel, wr_en, mem_req});
        end
    endtask

    task automatic test_st();
        wait_req();
        mem_ack = 1'b1; mem_rdata = 8'h7C;
        @(negedge clk); mem_ack = 1'b0; #1;
        vectors++;
        if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL st_decode_wr_en: got %b expected 0", wr_en); end
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'h00; #1;
        vectors++;
        if ({mem_req, mem_we, addr_sel, rd0_num, rd1_num, wr_en, mdr_load} !== {1'b1, 1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL st_mem: got %b expected 111110000", {mem_req, mem_we, addr_sel, rd0_num, rd1_num, wr_en, mdr_load});
        end
        @(negedge clk); mem_ack = 1'b0; #1;
        vectors++;
        if ({mem_req, addr_sel, mem_we, wr_en} !== 4'b1000) begin
            miscompares++; $display("[TB] FAIL st_refetch: got %b expected 1000", {mem_req, addr_sel, mem_we, wr_en});
        end
    endtask

    task automatic test_li();
        wait_req();
        mem_ack = 1'b1; mem_rdata = 8'h84; #1;
        vectors++;
        if (pc_en !== 1'b1) begin miscompares++; $display("[TB] FAIL li_pc_en1: got %b expected 1", pc_en); end
        @(negedge clk); mem_ack = 1'b0; #1;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'h5A; #1;
        vectors++;
        if ({mem_req, addr_sel, pc_en, mdr_load, wr_en} !== 5'b10110) begin
            miscompares++; $display("[TB] FAIL li_imm: got %b expected 10110", {mem_req, addr_sel, pc_en, mdr_load, wr_en});
        end
        @(negedge clk); mem_ack = 1'b0; #1;
        vectors++;
        if ({wr_num, wr_sel, wr_en, pc_en} !== {2'd1, 2'd1, 1'b1, 1'b0}) begin
            miscompares++; $display("[TB] FAIL li_wb: got %b expected 010110", {wr_num, wr_sel, wr_en, pc_en});
        end
    endtask

    task automatic test_alu_ops();
        logic [7:0] instr [5] = '{8'h2D, 8'h31, 8'h4E, 8'h57, 8'h00};
        logic [7:0] exp_ex [5] = '{{1'b1, 2'd3, 2'd0, 3'd1}, {1'b1, 2'd0, 2'd0, 3'd2},
                                   {1'b1, 2'd3, 2'd0, 3'd3}, {1'b1, 2'd1, 2'd2, 3'd0},
                                   8'h00};
        for (int i = 0; i < 5; i++) begin
            wait_req();
            mem_ack = 1'b1; mem_rdata = instr[i];
            @(negedge clk); mem_ack = 1'b0;
            @(negedge clk); #1;
            vectors++;
            if ({wr_en, wr_num, wr_sel, alu_op} !== exp_ex[i]) begin
                miscompares++;
                $display("[TB] FAIL exec_%02h: got %b expected %b", instr[i], {wr_en, wr_num, wr_sel, alu_op}, exp_ex[i]);
            end
            vectors++;
            if (mem_req !== 1'(i == 4)) begin
                miscompares++; $display("[TB] FAIL latency_%02h: mem_req got %b expected %b", instr[i], mem_req, (i == 4));
            end
        end
    endtask

    task automatic test_illegal_halt();
        wait_req();
        mem_ack = 1'b1; mem_rdata = 8'h9F;
        @(negedge clk); mem_ack = 1'b0; #1;
        vectors++;
        if ({illegal, wr_en} !== 2'b10) begin
            miscompares++; $display("[TB] FAIL illegal_decode: got %b expected 10", {illegal, wr_en});
        end
        @(negedge clk); #1;
        vectors++;
        if ({illegal, mem_req, wr_en} !== 3'b010) begin
            miscompares++; $display("[TB] FAIL illegal_after: got %b expected 010", {illegal, mem_req, wr_en});
        end
        mem_ack = 1'b1; mem_rdata = 8'hF0;
        @(negedge clk); mem_ack = 1'b0; #1;
        @(negedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            mem_ack = 1'b1; #1;
            vectors++;
            if ({mem_req, halted, pc_en, wr_en} !== 4'b0100) begin
                miscompares++; $display("[TB] FAIL halt_hold[%0d]: got %b expected 0100", i, {mem_req, halted, pc_en, wr_en});
            end
            @(negedge clk); #1;
        end
        mem_ack = 1'b0; reset = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_reset: got %b expected 0", halted); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        @(negedge clk); #1;
        wait_req();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_wait_hold: got %b expected 1", mem_req); end
        reset = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if ({mem_req, wr_en, instret} !== 18'd0) begin
            miscompares++; $display("[TB] FAIL reset_mid: req=%b wr_en=%b instret=%0d expected 0", mem_req, wr_en, instret);
        end
        reset = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_instret();
        logic [15:0] exp_cnt;
`ifdef MC_CONTROL_INSTRET_EN
        exp_cnt = 16'd5;
`else
        exp_cnt = 16'd0;
`endif
        feed(8'h00);
        feed(8'h16);
        feed(8'h7C); feed(8'h00);
        feed(8'h84); feed(8'h5A);
        feed(8'h6B); feed(8'h33);
        wait_req();
        vectors++;
        if (instret !== exp_cnt) begin
            miscompares++; $display("[TB] FAIL instret_count: got %0d expected %0d", instret, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld_wait();
        test_st();
        test_li();
        test_alu_ops();
        test_illegal_halt();
        test_reset_mid();
        test_instret();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle control FSM for the 8-bit, 4-register processor.
- Fetches one-byte instructions over a req/ack memory handshake and holds them in an internal IR.
- Sequences the register file (read numbers, write number, write enable), ALU op select, write-data mux, PC increment and MDR load.
- Sits between instruction/data memory and the datapath; one instruction in flight at a time.

Parameters:
- N, 8, datapath/instruction byte width; IR and mem_rdata are N bits; fixed at 8 for this ISA.
- RST_PC_EN_DLY, 0, idle cycles after reset before the first FETCH request (0-3).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- mem_rdata  input  N  memory read data; valid in the cycle mem_ack=1.
- mem_ack  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request; held until the cycle of mem_ack.
- mem_we  output  1  store request (valid with mem_req).
- addr_sel  output  1  0 = address from PC, 1 = address from rd1_data.
- pc_en  output  1  one-cycle PC increment pulse.
- mdr_load  output  1  datapath latches mem_rdata into MDR this cycle.
- rd0_num, rd1_num  output  2  register read selects.
- wr_num  output  2  register write select.
- wr_en  output  1  register write enable (one cycle).
- wr_sel  output  2  write-data source: 0 = ALU, 1 = MDR, 2 = rd1_data (MOV).
- alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR.
- illegal  output  1  one-cycle pulse on an undefined opcode.
- halted  output  1  high in HALT.
- instret  output  16  retired-instruction count (optional feature).

Behaviour:
- Instruction format: op = IR[7:4], rd = IR[3:2], rs = IR[1:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: rd <= rd op rs.
  - 5 MOV: rd <= rs.
  - 6 LD: rd <= mem[rs].
  - 7 ST: mem[rs] <= rd.
  - 8 LI: rd <= next byte.
  - F HALT.
  - 9-E illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, IMM, WB, HALT. Outputs are decoded from registered state and IR (Moore); only the state/IR/counters are flops.
- While reset=1: state <= IDLE, IR <= 0, delay counter <= 0, instret <= 0; every output is 0.
- IDLE: waits RST_PC_EN_DLY cycles, then goes to FETCH.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. On mem_ack: IR <= mem_rdata, pc_en=1, mdr_load=0, next state DECODE.
- DECODE (1 cycle):
  - Drives rd0_num=rd, rd1_num=rs.
  - Next state: ALU ops and MOV -> EXEC; LD/ST -> MEM; LI -> IMM; HALT -> HALT; NOP -> FETCH.
  - Illegal opcode: illegal=1 for this cycle, then treated as NOP.
- EXEC (1 cycle):
  - rd0_num=rd, rd1_num=rs, wr_num=rd, wr_en=1.
  - ALU ops: wr_sel=0, alu_op=op-1. MOV: wr_sel=2.
  - Next state FETCH.
- MEM:
  - mem_req=1, addr_sel=1, rd1_num=rs, rd0_num=rd (store data); mem_we=1 for ST.
  - On ack: LD asserts mdr_load and goes to WB; ST goes to FETCH.
- IMM: mem_req=1, addr_sel=0. On ack: pc_en=1, mdr_load=1, next state WB.
- WB (1 cycle): wr_num=rd, wr_sel=1, wr_en=1, next state FETCH.
- HALT: halted=1, every other output is 0; leaves only on reset.
- Handshake rules:
  - mem_req and its qualifiers (addr_sel, mem_we) are stable from assertion through the ack cycle.
  - mem_ack with mem_req=0 is ignored.
  - An ack in the first request cycle is legal (zero wait).
  - Wait states are unbounded.
- Latency with zero-wait memory:
  - NOP: 2 cycles.
  - ALU/MOV: 3 cycles.
  - ST: 3 cycles.
  - LD/LI: 4 cycles.
- Reset mid-handshake: the request is dropped in the next cycle and the partial instruction is discarded; no write occurs.
- wr_en is never asserted in the same cycle as mem_req.

Optional Feature:
- MC_CONTROL_INSTRET_EN defined:
  - instret increments (wrapping at 16'hFFFF -> 0) on every cycle that leaves EXEC or WB, every ST ack in MEM, every NOP/illegal in DECODE, and on entry to HALT.
  - instret is cleared by reset.
- MC_CONTROL_INSTRET_EN undefined: the instret port still exists, is tied to 0 and has no flops.

Decomposition:
- Package mc_pkg:
  - state enum.
  - opcode constants (OP_NOP..OP_HALT).
  - alu_op constants.
  - wr_sel constants (WSEL_ALU, WSEL_MDR, WSEL_REG).
- One sub-module, mc_decode: combinational map of op to class (alu/mov/ld/st/li/halt/nop/illegal) and alu_op. The FSM stays in mc_control.

Test Plan:
- ADD: reset 2 cycles, memory returns 8'h16 zero-wait -> FETCH ack cycle pc_en=1; DECODE rd0_num=1, rd1_num=2; EXEC wr_en=1, wr_num=1, wr_sel=0, alu_op=0; next cycle mem_req=1.
- LD, 3 wait states: 8'h6B -> MEM holds mem_req=1, addr_sel=1, rd1_num=3 for 4 cycles; ack cycle mdr_load=1; WB wr_num=2, wr_sel=1, wr_en=1.
- ST: 8'h7C -> MEM mem_we=1, rd0_num=3, rd1_num=0; no wr_en anywhere; back to FETCH after ack.
- LI: bytes 8'h84, 8'h5A -> two pc_en pulses; IMM mdr_load=1; WB wr_num=1, wr_en=1.
- Illegal and HALT: 8'h9F -> illegal=1 for one DECODE cycle, no wr_en; then 8'hF0 -> halted=1 and mem_req stays 0 for 20 cycles; reset -> halted=0.
- Reset during FETCH wait: mem_req drops the cycle after reset, instret=0; with MC_CONTROL_INSTRET_EN, 5 retired instructions -> instret=5.
